// File: rtl/hdsiso_pkg.sv
// Shared constants and helpers for the high-density SISO delay line.
package hdsiso_pkg;

   localparam int JOHNSON_W = 4;
   localparam int N_PHASES  = 8;

   // Legal Johnson states, phase 0..7
   localparam logic [JOHNSON_W-1:0] JS0 = 4'b0000;
   localparam logic [JOHNSON_W-1:0] JS1 = 4'b0001;
   localparam logic [JOHNSON_W-1:0] JS2 = 4'b0011;
   localparam logic [JOHNSON_W-1:0] JS3 = 4'b0111;
   localparam logic [JOHNSON_W-1:0] JS4 = 4'b1111;
   localparam logic [JOHNSON_W-1:0] JS5 = 4'b1110;
   localparam logic [JOHNSON_W-1:0] JS6 = 4'b1100;
   localparam logic [JOHNSON_W-1:0] JS7 = 4'b1000;

   // One-hot phase decode of a Johnson state; illegal states decode to all zeros
   function automatic logic [N_PHASES-1:0] johnson_decode(input logic [JOHNSON_W-1:0] j);
      logic [N_PHASES-1:0] onehot;
      onehot = '0;
      case (j)
         JS0:     onehot = 8'h01;
         JS1:     onehot = 8'h02;
         JS2:     onehot = 8'h04;
         JS3:     onehot = 8'h08;
         JS4:     onehot = 8'h10;
         JS5:     onehot = 8'h20;
         JS6:     onehot = 8'h40;
         JS7:     onehot = 8'h80;
         default: onehot = 8'h00;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/hdsiso_core_johnson8_seq.sv
// 8-state Johnson bit-phase sequencer with one-hot phase decode.
module johnson8_seq
   import hdsiso_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   output logic [JOHNSON_W-1:0] o_johnson,
   output logic [N_PHASES-1:0]  o_pulses
);

   logic [JOHNSON_W-1:0] r_j;

   // Twisted-ring shift, advancing one phase per enabled cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_j <= JS0;
      end else if (i_en) begin
         r_j <= {r_j[JOHNSON_W-2:0], ~r_j[JOHNSON_W-1]};
      end
   end

   // Phase state straight from the flops; one-hot decode is purely combinational
   always_comb begin
      o_johnson = r_j;
      o_pulses  = johnson_decode(r_j);
   end

endmodule

// File: rtl/hdsiso_core.sv
// Serial-in serial-out delay line: bits are packed into bytes, held in a
// circular byte buffer, and serialised back out DEPTH+1 words later.
module hdsiso_core
   import hdsiso_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 ENABLE,
   input  logic                 D_IN,
   output logic                 D_OUT,
   output logic [JOHNSON_W-1:0] JOHNSON,
   output logic [N_PHASES-1:0]  PULSES
);

   // Derived pointer width, at least one bit so DEPTH=1 still has a legal vector
   localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

   logic [N_PHASES-2:0] r_in_buf;
   logic [N_PHASES-1:0] r_out_sh;
   logic [PTR_W-1:0]    r_ptr;
   logic [N_PHASES-1:0] r_mem [DEPTH];

   logic                w_phase7;
   logic [N_PHASES-1:0] w_byte;

   johnson8_seq u_seq (
      .i_clk     (CLK),
      .i_rst_n   (RESET),
      .i_en      (ENABLE),
      .o_johnson (JOHNSON),
      .o_pulses  (PULSES)
   );

   // Word boundary strobe and the completed byte (bit p captured in phase p)
   always_comb begin
      w_phase7 = ENABLE & PULSES[N_PHASES-1];
      w_byte   = {D_IN, r_in_buf};
   end

   // Deserialiser: capture D_IN into the bit selected by the current phase
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_in_buf <= '0;
      end else if (ENABLE) begin
         for (int i = 0; i < N_PHASES - 1; i++) begin
            if (PULSES[i]) r_in_buf[i] <= D_IN;
         end
      end
   end

   // Circular byte buffer: new byte overwrites the slot just read out
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_phase7) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_ptr == PTR_W'(i)) r_mem[i] <= w_byte;
         end
      end
   end

   // Read-before-write: load the oldest byte into the serialiser, then advance the slot pointer
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_out_sh <= '0;
         r_ptr    <= '0;
      end else if (w_phase7) begin
         r_out_sh <= r_mem[r_ptr];
         r_ptr    <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      end
   end

   // Serialiser: pick the bit of the held byte matching the current phase (registers only)
   always_comb begin
      D_OUT = |(r_out_sh & PULSES);
   end

endmodule
